// File: rtl/inv_mix_col_seq.sv
// inv_mix_col_seq
//   Column-serial AES MixColumns / InvMixColumns engine. A 128-bit state
//   block is captured on an input handshake. One column is transformed per
//   clock through a single shared set of GF(2^8) constant multipliers. The
//   result is then offered on the output side until the consumer accepts it.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both 1. in_ready is 1 only in IDLE. out_valid is 1 only
//   in DONE, and out_state is held stable there until out_ready is seen.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    upstream offers a block
//   in_ready   out  1    engine is idle and can take a block
//   in_state   in   128  block; column j = [127-32j : 96-32j], byte 0 = MSB
//   in_inv     in   1    1 = InvMixColumns, 0 = MixColumns
//   out_valid  out  1    out_state holds a finished result
//   out_ready  in   1    downstream takes the result
//   out_state  out  128  result, same layout as in_state
//   busy       out  1    engine is not idle
module inv_mix_col_seq #(
    parameter int NCOL = 4  // columns per block; only 4 is meaningful
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*NCOL-1:0]   in_state,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NCOL-1:0]   out_state,
    output logic                 busy
);

    localparam int BLK_W = 32 * NCOL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [BLK_W-1:0]   blk;
    logic               inv_r;
    logic [1:0]         col_cnt;
    logic [BLK_W-1:0]   res;
    logic [6:0]         col_base;
    logic [31:0]        col_in;
    logic [31:0]        col_out;
    logic [7:0]         a [4];

    // Multiply by x (0x02) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant product for the term in rotation position pos:
    //   inverse coefficients 14, 11, 13, 9 ; forward 2, 3, 1, 1.
    function automatic logic [7:0] coef_mul(input logic [7:0] v,
                                            input logic [1:0] pos,
                                            input logic       inv);
        logic [7:0] x2, x4, x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        coef_mul = v;
        if (inv) begin
            case (pos)
                2'd0:    coef_mul = x8 ^ x4 ^ x2;  // 14
                2'd1:    coef_mul = x8 ^ x2 ^ v;   // 11
                2'd2:    coef_mul = x8 ^ x4 ^ v;   // 13
                default: coef_mul = x8 ^ v;        // 9
            endcase
        end else begin
            case (pos)
                2'd0:    coef_mul = x2;            // 2
                2'd1:    coef_mul = x2 ^ v;        // 3
                default: coef_mul = v;             // 1
            endcase
        end
    endfunction

    // Column j sits at bit offset 32*(3-j); ~col_cnt is 3-col_cnt.
    assign col_base = {~col_cnt, 5'd0};
    assign col_in   = blk[col_base +: 32];

    assign a[0] = col_in[31:24];
    assign a[1] = col_in[23:16];
    assign a[2] = col_in[15:8];
    assign a[3] = col_in[7:0];

    // One multiplier set per output byte, shared by all four columns.
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign col_out[31-8*i -: 8] = coef_mul(a[i],         2'd0, inv_r)
                                    ^ coef_mul(a[(i+1) % 4], 2'd1, inv_r)
                                    ^ coef_mul(a[(i+2) % 4], 2'd2, inv_r)
                                    ^ coef_mul(a[(i+3) % 4], 2'd3, inv_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            blk     <= '0;
            inv_r   <= 1'b0;
            col_cnt <= 2'd0;
            res     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        blk     <= in_state;
                        inv_r   <= in_inv;
                        col_cnt <= 2'd0;
                    end
                end
                CALC: begin
                    res[col_base +: 32] <= col_out;
                    // Wraps 3 -> 0 exactly when CALC is left.
                    col_cnt <= col_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                if (col_cnt == 2'd3) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign out_state = res;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Bench for inv_mix_col_seq: random and directed blocks are pushed into an
// expected queue on acceptance and popped by an output monitor.
module tb_inv_mix_col_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int accept_cyc = -1;
    int last_acc   = -1;
    bit ov_prev    = 0;
    bit check_period = 0;
    logic [127:0] last_out = '0;
    logic [127:0] exp_q[$];

    inv_mix_col_seq #(.NCOL(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] gmul(input int x, input int y);
        int p = 0;
        for (int i = 0; i < 8; i++) if ((y >> i) & 1) p = p ^ (x << i);
        for (int b = 14; b >= 8; b--) if ((p >> b) & 1) p = p ^ (32'h11b << (b - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        int coef[4];
        logic [7:0] a[4];
        logic [7:0] b;
        logic [127:0] r = '0;
        if (inv) coef = '{14, 11, 13, 9};
        else     coef = '{2, 3, 1, 1};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(coef[k], int'(a[(i + k) % 4]));
                r[127 - 32*c - 8*i -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- input-side monitor (scoreboard push, latency) ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            accept_cyc = -1;
            ov_prev    = 0;
        end else begin
            if (out_valid && !ov_prev && accept_cyc >= 0)
                check("latency", 128'(cyc - accept_cyc), 128'd4);
            ov_prev = out_valid;
            if (in_valid && in_ready) begin
                // transfer happens on the next rising edge
                accept_cyc = cyc + 1;
                exp_q.push_back(model(in_state, in_inv));
                if (check_period && last_acc >= 0)
                    check("accept_period", 128'(accept_cyc - last_acc), 128'd6);
                last_acc = accept_cyc;
            end
        end
    end

    // ---------------- output-side monitor (scoreboard pop) ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h required no output", out_state);
            end else begin
                check("out_state", out_state, exp_q.pop_front());
            end
            last_out = out_state;
            done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] d, input logic inv);
        int k = 0;
        in_state = d;
        in_inv   = inv;
        in_valid = 1;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 50);
        if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 0;
        // scramble the inputs; the in-flight block must not notice
        in_state = rand128();
        in_inv   = ~inv;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < target) check("result_timeout", 128'(done_cnt), 128'(target));
        @(posedge clk);
        #1;
    endtask

    task automatic do_block(input logic [127:0] d, input logic inv);
        int target = done_cnt + 1;
        send(d, inv);
        wait_done(target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] vec_a, vec_b, x, f, expd;
        int k, target, d0;
        bit seen;

        vec_a = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        vec_b = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

        rst_n = 0; in_valid = 0; in_state = '0; in_inv = 0; out_ready = 1;
        #12;
        check("rst_out_state", out_state, '0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy), 128'd0);
        check("rst_in_ready",  128'(in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // directed known-answer vectors
        do_block(vec_a, 1'b1);
        check("kat_inverse", last_out, vec_b);
        do_block(vec_b, 1'b0);
        check("kat_forward", last_out, vec_a);

        // output back-pressure: result must hold while out_ready is low
        out_ready = 0;
        x = rand128();
        k = $urandom_range(0, 1);
        expd = model(x, k[0]);
        send(x, k[0]);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid_seen", 128'(out_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", 128'(out_valid), 128'd1);
            check("stall_out_state", out_state, expd);
            check("stall_in_ready",  128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("release_in_ready",  128'(in_ready), 128'd1);
        check("release_out_valid", 128'(out_valid), 128'd0);
        check("release_busy",      128'(busy), 128'd0);
        check("retain_out_state",  out_state, expd);

        // reset in the middle of CALC (col_cnt = 2)
        d0 = done_cnt;
        send(rand128(), 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        exp_q.delete();
        check("abort_out_state", out_state, '0);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_busy",      128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_valid", 128'(seen), 128'd0);
        check("abort_no_result", 128'(done_cnt), 128'(d0));
        @(posedge clk);
        #1;
        x = rand128();
        do_block(x, 1'b0);
        check("after_abort", last_out, model(x, 1'b0));

        // round trip forward then inverse
        for (int n = 0; n < 1000; n++) begin
            x = rand128();
            do_block(x, 1'b0);
            f = last_out;
            do_block(f, 1'b1);
            check("round_trip", last_out, x);
        end

        // in_valid held high: one accept every 6 cycles, nothing lost
        target = done_cnt + 8;
        last_acc = -1;
        check_period = 1;
        in_valid = 1;
        for (int n = 0; n < 8; n++) begin
            in_state = rand128();
            in_inv = $urandom_range(0, 1);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!in_ready && k < 20);
            if (!in_ready) check("stream_accept_timeout", 128'(in_ready), 128'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        wait_done(target);
        check_period = 0;
        check("stream_count", 128'(done_cnt), 128'(target));
        check("queue_empty",  128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_mix_col_seq.md
INV_MIX_COL_SEQ -- requirements
Module: inv_mix_col_seq

Interface
REQ-001 SHALL have parameter NCOL, default 4, number of 32-bit columns per state; only 4 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream has a state block ready to transfer.
REQ-005 SHALL have port in_ready  output  1  block can accept a state block.
REQ-006 SHALL have port in_state  input  128  state block; column j = bits [127-32j : 96-32j]; byte 0 of a column is its MSB.
REQ-007 SHALL have port in_inv  input  1  1 = InvMixColumns, 0 = forward MixColumns.
REQ-008 SHALL have port out_valid  output  1  out_state holds a finished result.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_state  output  128  result block, same byte layout as in_state.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; an input transfer occurs on an edge where in_valid & in_ready.
REQ-014 On an input transfer SHALL latch in_state and in_inv, clear col_cnt to 0, and enter CALC.
REQ-015 In CALC SHALL process one column per cycle through one shared set of four GF(2^8) constant multipliers per output byte; no replication per column.
REQ-016 SHALL write the result for column col_cnt into the out_state column col_cnt at each CALC edge, then increment col_cnt.
REQ-017 Inverse mode SHALL compute b_i = 14*a_i ^ 11*a_(i+1) ^ 13*a_(i+2) ^ 9*a_(i+3); indices are mod 4.
REQ-018 Forward mode SHALL compute b_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3); indices are mod 4.
REQ-019 All products SHALL use GF(2^8) with reduction polynomial 0x11B; checks: 14*0x01=0x0E, 14*0x80=0x41, 14*0xFF=0x8D.
REQ-020 After the col_cnt=3 edge, SHALL enter DONE; out_valid rises 4 edges after the transfer edge. Latency is 4 cycles, fixed, and independent of mode.
REQ-021 SHALL hold out_valid = 1 and out_state stable in DONE until out_ready = 1 at an edge, then enter IDLE.
REQ-022 SHALL not accept new input in CALC or DONE (in_ready = 0); out_ready is ignored outside DONE.
REQ-023 out_ready high in the same cycle out_valid first rises SHALL complete the transfer at that edge; the minimum back-to-back period is 6 cycles.
REQ-024 Changes on in_state/in_inv after the transfer edge SHALL not affect the in-flight result.
REQ-025 out_state SHALL retain the last result after returning to IDLE, until column 0 of the next operation overwrites it.
REQ-026 col_cnt SHALL be 2 bits and wrap only by FSM exit; it has no other use.

Reset
REQ-027 rst_n = 0 SHALL immediately force IDLE, col_cnt = 0, out_state = 0, out_valid = 0, busy = 0; in_ready = 1 once rst_n = 1.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation; no out_valid pulse follows for it.

Verification
REQ-029 inv=1, in_state 8e4da1bc_9f dc589d_01010101_c6c6c6c6 (spaces ignored) -> out_state db135345_f20a225c_01010101_c6c6c6c6, out_valid 4 edges after accept.
REQ-030 inv=0, in_state db135345_f20a225c_01010101_c6c6c6c6 -> 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-031 Round-trip: random 1000 blocks, forward then inverse -> the original block each time.
REQ-032 out_ready held low 10 cycles -> out_valid and out_state stable, in_ready = 0; then out_ready = 1 -> IDLE next edge, in_ready = 1.
REQ-033 rst_n pulsed low at col_cnt = 2 -> out_state = 0, out_valid never asserts, next block processes correctly.
REQ-034 in_valid held high continuously with out_ready = 1 -> one accept every 6 cycles, results in order, no block lost or duplicated.
